// File: rtl/rm_violation_reporter_pkg.sv
// Shared types and constants for the runtime-monitor violation reporter.
// Holds default sizing, the violation record layout and a saturating helper.
package rm_violation_reporter_pkg;

   localparam int unsigned RM_NUM_LANES  = 4;
   localparam int unsigned RM_NUM_RULES  = 5;
   localparam int unsigned RM_FIFO_DEPTH = 8;
   localparam int unsigned RM_TS_WIDTH   = 16;
   localparam int unsigned RM_DROP_CNT_W = 8;

   typedef struct packed {
      logic [$clog2(RM_NUM_LANES)-1:0] lane;
      logic [RM_NUM_RULES-1:0]         rules;
      logic [RM_TS_WIDTH-1:0]          ts;
   } rm_violation_t;

   function automatic logic [RM_DROP_CNT_W-1:0] rm_sat_inc(
      input logic [RM_DROP_CNT_W-1:0] v
   );
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/rm_rr_arbiter.sv
// Round-robin arbiter over lane requests, searching from last grant + 1.
// Ports: clk_i/rst_ni, req_i, en_i (grant allowed),
//        gnt_o (one-hot), gnt_idx_o, gnt_valid_o.
module rm_rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned LW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [N-1:0]  req_i,
   input  logic          en_i,
   output logic [N-1:0]  gnt_o,
   output logic [LW-1:0] gnt_idx_o,
   output logic          gnt_valid_o
);

   logic [LW-1:0] last_q;
   logic [LW-1:0] last_d;
   logic [LW-1:0] cand;
   logic          found;
   int            t;

   always_comb begin
      gnt_idx_o = '0;
      found     = 1'b0;
      cand      = '0;
      t         = 0;
      for (int i = 1; i <= int'(N); i++) begin
         t = int'(last_q) + i;
         if (t >= int'(N)) t = t - int'(N);
         cand = LW'(t);
         if (!found && req_i[cand]) begin
            found     = 1'b1;
            gnt_idx_o = cand;
         end
      end
      gnt_valid_o = found & en_i;
      gnt_o       = '0;
      if (gnt_valid_o) gnt_o[gnt_idx_o] = 1'b1;
      last_d = gnt_valid_o ? gnt_idx_o : last_q;
   end

   // Reset to the highest lane so lane 0 is searched first.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) last_q <= LW'(N - 1);
      else         last_q <= last_d;
   end

endmodule

// File: rtl/rm_violation_reporter.sv
// Turns rising per-lane rule violations into timestamped records queued
// in a FIFO drained over valid/ready; raises irq and tracks lost edges.
// Ports: clk_i/rst_ni, monitor_i, lane_reset_i, rec_valid_o/rec_ready_i,
//        rec_lane_o/rec_rules_o/rec_ts_o, irq_o, overflow_o,
//        drop_cnt_o, clear_i.
module rm_violation_reporter
   import rm_violation_reporter_pkg::*;
#(
   parameter int unsigned NUM_LANES  = RM_NUM_LANES,
   parameter int unsigned NUM_RULES  = RM_NUM_RULES,
   parameter int unsigned FIFO_DEPTH = RM_FIFO_DEPTH,
   parameter int unsigned TS_WIDTH   = RM_TS_WIDTH,
   parameter int unsigned LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NUM_LANES-1:0][NUM_RULES-1:0] monitor_i,
   input  logic [NUM_LANES-1:0]                lane_reset_i,
   output logic                                rec_valid_o,
   input  logic                                rec_ready_i,
   output logic [LW-1:0]                       rec_lane_o,
   output logic [NUM_RULES-1:0]                rec_rules_o,
   output logic [TS_WIDTH-1:0]                 rec_ts_o,
   output logic                                irq_o,
   output logic                                overflow_o,
   output logic [RM_DROP_CNT_W-1:0]            drop_cnt_o,
   input  logic                                clear_i
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned EW = LW + NUM_RULES + TS_WIDTH;

   logic [NUM_LANES-1:0][NUM_RULES-1:0] prev_q, prev_d;
   logic [NUM_LANES-1:0][NUM_RULES-1:0] pend_q, pend_d;
   logic [NUM_LANES-1:0][NUM_RULES-1:0] new_s;
   logic [NUM_LANES-1:0]                req;
   logic [NUM_LANES-1:0]                gnt_oh;
   logic [LW-1:0]                       gnt_idx;
   logic                                gnt_vld;
   logic                                loss;

   logic [TS_WIDTH-1:0]      ts_q, ts_d;
   logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     ovf_q, ovf_d;
   logic [RM_DROP_CNT_W-1:0] drop_q, drop_d;
   logic [EW-1:0]            mem [FIFO_DEPTH];
   logic [EW-1:0]            head;
   logic                     full;
   logic                     push;
   logic                     pop;

   assign full = (cnt_q == CW'(FIFO_DEPTH));
   assign push = gnt_vld;
   assign pop  = rec_valid_o & rec_ready_i;

   always_comb begin
      for (int l = 0; l < int'(NUM_LANES); l++) begin
         req[l] = |pend_q[l];
      end
   end

   rm_rr_arbiter #(
      .N  (NUM_LANES),
      .LW (LW)
   ) u_arb (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_i       (req),
      .en_i        (~full),
      .gnt_o       (gnt_oh),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (gnt_vld)
   );

   // Lane release suppresses the edge and clears all lane state.
   // The granted lane keeps only this cycle's fresh edges.
   always_comb begin
      loss = 1'b0;
      for (int l = 0; l < int'(NUM_LANES); l++) begin
         new_s[l]  = '0;
         prev_d[l] = '0;
         pend_d[l] = '0;
         if (!lane_reset_i[l]) begin
            new_s[l]  = monitor_i[l] & ~prev_q[l];
            prev_d[l] = monitor_i[l];
            if (gnt_oh[l]) begin
               pend_d[l] = new_s[l];
            end else begin
               pend_d[l] = pend_q[l] | new_s[l];
               if (|(new_s[l] & pend_q[l])) loss = 1'b1;
            end
         end
      end
   end

   // A loss in the clearing cycle restarts the count at one.
   always_comb begin
      ovf_d  = ovf_q;
      drop_d = drop_q;
      if (loss) begin
         ovf_d  = 1'b1;
         drop_d = clear_i ? RM_DROP_CNT_W'(1) : rm_sat_inc(drop_q);
      end else if (clear_i) begin
         ovf_d  = 1'b0;
         drop_d = '0;
      end
   end

   always_comb begin
      ts_d     = ts_q + 1'b1;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d    = cnt_q;
      if (push && !pop) cnt_d = cnt_q + 1'b1;
      if (!push && pop) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         prev_q   <= '0;
         pend_q   <= '0;
         ts_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
      end else begin
         prev_q   <= prev_d;
         pend_q   <= pend_d;
         ts_q     <= ts_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end

   // Storage needs no reset: outputs are masked while empty.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr_q] <= {gnt_idx, pend_q[gnt_idx], ts_q};
   end

   assign head        = mem[rd_ptr_q];
   assign rec_valid_o = (cnt_q != '0);
   assign rec_lane_o  = rec_valid_o ? head[EW-1 -: LW] : '0;
   assign rec_rules_o = rec_valid_o ? head[TS_WIDTH +: NUM_RULES] : '0;
   assign rec_ts_o    = rec_valid_o ? head[TS_WIDTH-1:0] : '0;
   assign overflow_o  = ovf_q;
   assign drop_cnt_o  = drop_q;
   assign irq_o       = rec_valid_o | ovf_q;

endmodule
